spw_ulight_pio_ctrl: RTL and testbench

//  Parametrised Avalon-MM PIO control register for the SpW uLight system. Successor to the 1-bit static output PIO.
//  - WIDTH-bit output port, with atomic SET/CLR writes and self-clearing pulse mode.
//  - Pulse mode drives auto-start/link-enable strobes from software without a second write.
//  - Sits between the Nios/Avalon interconnect and the SpW link-control inputs.

---
 rtl/spw_ulight_pio_ctrl_pkg.sv | 29 ++
 rtl/spw_ulight_pio_ctrl_if.sv | 33 +++
 rtl/spw_ulight_pio_ctrl_edge_cap.sv | 51 +++++
 rtl/spw_ulight_pio_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spw_ulight_pio_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/spw_ulight_pio_ctrl_pkg.sv
// ============================================================================
// spw_pio_pkg : register map and pulse-FSM types for the SpW uLight PIO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package spw_pio_pkg;

  localparam int ADDR_W    = 3;
  localparam int BUS_W     = 32;
  localparam int STATUS_WIDTH_LSB = 8;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLR     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PULSE   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_LEN     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pulse_state_e;

endpackage

`default_nettype wire

// File: rtl/spw_ulight_pio_ctrl_if.sv
// ============================================================================
// spw_ulight_pio_ctrl_if : Avalon-MM slave bus bundle for the PIO control block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface spw_ulight_pio_ctrl_if;
  import spw_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/spw_ulight_pio_ctrl_edge_cap.sv
// ============================================================================
// spw_pio_edge_cap : input synchroniser, rising-edge detect, sticky W1C flags
// and registered masked interrupt. Used only when SPW_PIO_EDGE_IRQ_EN is set.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_pio_edge_cap #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] in_port_i,
  input  wire logic [WIDTH-1:0] clr_i,
  input  wire logic [WIDTH-1:0] mask_i,
  output logic      [WIDTH-1:0] edge_o,
  output logic                  irq_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q;
  logic             irq_q;
  logic [WIDTH-1:0] rise;

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // A new edge outranks a simultaneous software clear of the same bit.
      edge_q  <= (edge_q & ~clr_i) | rise;
      irq_q   <= |(edge_q & mask_i);
    end
  end

  assign edge_o = edge_q;
  assign irq_o  = irq_q;

endmodule

`default_nettype wire

// File: rtl/spw_ulight_pio_ctrl.sv
// ============================================================================
// spw_ulight_pio_ctrl : WIDTH-bit Avalon-MM PIO with SET/CLR and timed pulses.
// Optional edge capture + IRQ enabled by defining SPW_PIO_EDGE_IRQ_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_ulight_pio_ctrl
  import spw_pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter int               PULSE_DEF = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  spw_ulight_pio_ctrl_if.slave  bus,
  output logic      [WIDTH-1:0] out_port
`ifdef SPW_PIO_EDGE_IRQ_EN
  ,
  input  wire logic [WIDTH-1:0] in_port,
  output logic                  irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_RST = CNT_W'(PULSE_DEF);

  pulse_state_e     state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             wr_en;
  logic             pulse_wr;
  logic             busy;
  logic [WIDTH-1:0] wdata;
  logic [CNT_W-1:0] len_wdata;
  logic [CNT_W-1:0] cnt_load;
  logic [BUS_W-1:0] rdata;
  logic             unused_wdata;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign pulse_wr  = wr_en && (bus.address == ADDR_PULSE);
  assign wdata     = bus.writedata[WIDTH-1:0];
  assign len_wdata = bus.writedata[CNT_W-1:0];
  assign cnt_load  = (len_q == '0) ? CNT_ONE : len_q;
  assign busy      = (state_q == RUN);
  assign unused_wdata = &{1'b0, bus.writedata};

`ifdef SPW_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] edge_clr;

  assign edge_clr = (wr_en && (bus.address == ADDR_EDGE)) ? wdata : '0;

  spw_pio_edge_cap #(
    .WIDTH (WIDTH)
  ) u_edge_cap (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port_i (in_port),
    .clr_i     (edge_clr),
    .mask_i    (mask_q),
    .edge_o    (edge_flags),
    .irq_o     (irq)
  );
`endif

  always_comb begin
    out_d   = out_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    len_d   = len_q;
`ifdef SPW_PIO_EDGE_IRQ_EN
    mask_d  = mask_q;
`endif
    // Expiry is evaluated first so a same-cycle register write lands on top
    // of the release; a PULSE write instead reloads and skips the release.
    if ((state_q == RUN) && !pulse_wr) begin
      if (cnt_q == CNT_ONE) begin
        out_d   = out_q & ~pmask_q;
        pmask_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    if (wr_en) begin
      case (bus.address)
        ADDR_DATA: begin
          out_d   = wdata;
          pmask_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        ADDR_SET: out_d = out_d | wdata;
        ADDR_CLR: begin
          out_d   = out_d & ~wdata;
          pmask_d = pmask_d & ~wdata;
        end
        ADDR_PULSE: begin
          out_d   = out_q | wdata;
          pmask_d = pmask_q | wdata;
          cnt_d   = cnt_load;
          state_d = RUN;
        end
        ADDR_LEN: len_d = len_wdata;
`ifdef SPW_PIO_EDGE_IRQ_EN
        ADDR_IRQMASK: mask_d = wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= RESET_VAL;
      pmask_q <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_RST;
`ifdef SPW_PIO_EDGE_IRQ_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pmask_q <= pmask_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
`ifdef SPW_PIO_EDGE_IRQ_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA, ADDR_SET, ADDR_CLR: rdata[WIDTH-1:0] = out_q;
      ADDR_PULSE: rdata[WIDTH-1:0] = pmask_q;
      ADDR_LEN:   rdata[CNT_W-1:0] = len_q;
      ADDR_STATUS: begin
        rdata[0] = busy;
        rdata[STATUS_WIDTH_LSB +: 8] = 8'(WIDTH);
      end
`ifdef SPW_PIO_EDGE_IRQ_EN
      ADDR_EDGE:    rdata[WIDTH-1:0] = edge_flags;
      ADDR_IRQMASK: rdata[WIDTH-1:0] = mask_q;
`endif
      default: ;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;

endmodule

`default_nettype wire

// File: tb/tb_spw_ulight_pio_ctrl.sv
// ============================================================================
// tb_spw_ulight_pio_ctrl : scoreboard bench for the SpW uLight PIO control block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spw_ulight_pio_ctrl;
  import spw_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
`ifdef SPW_PIO_EDGE_IRQ_EN
  logic [7:0] in_port = '0;
  logic       irq;
`endif

  spw_ulight_pio_ctrl_if bus_if ();

  spw_ulight_pio_ctrl #(
    .WIDTH     (8),
    .CNT_W     (16),
    .PULSE_DEF (16),
    .RESET_VAL (8'h00)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.slave),
    .out_port (out_port)
`ifdef SPW_PIO_EDGE_IRQ_EN
    ,
    .in_port  (in_port),
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic sb_check(input logic [31:0] act);
    exp_t item;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      item = sb.pop_front();
      check_val(item.tag, act, item.exp);
    end
  endtask

  // One bus cycle (write, or STATUS read when w=0); afterwards {busy,out_port}
  // is compared to the expectation pushed for this cycle.
  task automatic step(input string tag, input bit w, input logic [2:0] a,
                      input logic [31:0] d, input bit exp_busy, input logic [7:0] exp_out);
    sb_push(tag, {23'b0, exp_busy, exp_out});
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = !w;
    bus_if.address    = w ? a : ADDR_STATUS;
    bus_if.writedata  = w ? d : 32'h0;
    @(posedge clk);
    #1;
    bus_if.write_n = 1'b1;
    bus_if.address = ADDR_STATUS;
    #1;
    sb_check({23'b0, bus_if.readdata[0], out_port});
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    sb_push(tag, exp);
    #1;
    sb_check(bus_if.readdata);
    bus_if.chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    sb_push("rst_out_port", 32'h0);
    sb_check({24'b0, out_port});
    rd("rst_data",    ADDR_DATA,    32'h0);
    rd("rst_set",     ADDR_SET,     32'h0);
    rd("rst_clr",     ADDR_CLR,     32'h0);
    rd("rst_pulse",   ADDR_PULSE,   32'h0);
    rd("rst_len",     ADDR_LEN,     32'd16);
    rd("rst_status",  ADDR_STATUS,  32'h0800);
    rd("rst_edge",    ADDR_EDGE,    32'h0);
    rd("rst_irqmask", ADDR_IRQMASK, 32'h0);

    // DATA / SET / CLR back to back
    step("t2_data", 1, ADDR_DATA, 32'hFFFF_FFA5, 0, 8'hA5);
    step("t2_set",  1, ADDR_SET,  32'h0000_000F, 0, 8'hAF);
    step("t2_clr",  1, ADDR_CLR,  32'h0000_0081, 0, 8'h2E);
    rd("t2_pmask", ADDR_PULSE, 32'h0);
    rd("t2_read_out", ADDR_DATA, 32'h2E);

    // 4-cycle pulse
    step("t3_data0", 1, ADDR_DATA, 32'h0, 0, 8'h00);
    step("t3_len",   1, ADDR_LEN,  32'd4, 0, 8'h00);
    rd("t3_len_rd", ADDR_LEN, 32'd4);
    step("t3_pulse", 1, ADDR_PULSE, 32'h01, 1, 8'h01);
    rd("t3_pmask", ADDR_PULSE, 32'h01);
    for (int i = 0; i < 3; i++) step("t3_run", 0, 3'd0, 32'h0, 1, 8'h01);
    step("t3_release", 0, 3'd0, 32'h0, 0, 8'h00);
    rd("t3_pmask_clr", ADDR_PULSE, 32'h0);

    // LEN=0 gives one cycle; reload during RUN merges bits
    step("t4_len0",   1, ADDR_LEN,   32'd0,  0, 8'h00);
    step("t4_pulse2", 1, ADDR_PULSE, 32'h02, 1, 8'h02);
    step("t4_rel1",   0, 3'd0, 32'h0, 0, 8'h00);
    step("t4_len10",  1, ADDR_LEN,   32'd10, 0, 8'h00);
    step("t4_pulse1", 1, ADDR_PULSE, 32'h01, 1, 8'h01);
    for (int i = 0; i < 4; i++) step("t4_run_a", 0, 3'd0, 32'h0, 1, 8'h01);
    step("t4_pulse4", 1, ADDR_PULSE, 32'h04, 1, 8'h05);
    for (int i = 0; i < 9; i++) step("t4_run_b", 0, 3'd0, 32'h0, 1, 8'h05);
    step("t4_rel_both", 0, 3'd0, 32'h0, 0, 8'h00);

    // SET on the expiry cycle wins for its bit
    step("t5_len2",    1, ADDR_LEN,   32'd2,  0, 8'h00);
    step("t5_pulse",   1, ADDR_PULSE, 32'h01, 1, 8'h01);
    step("t5_run",     0, 3'd0, 32'h0, 1, 8'h01);
    step("t5_set_exp", 1, ADDR_SET,   32'h01, 0, 8'h01);
    step("t5_hold",    0, 3'd0, 32'h0, 0, 8'h01);

    // PULSE on the expiry cycle reloads instead of releasing
    step("t5_data0",   1, ADDR_DATA,  32'h00, 0, 8'h00);
    step("t5_p1",      1, ADDR_PULSE, 32'h01, 1, 8'h01);
    step("t5_p1_run",  0, 3'd0, 32'h0, 1, 8'h01);
    step("t5_p2_exp",  1, ADDR_PULSE, 32'h02, 1, 8'h03);
    step("t5_p2_run",  0, 3'd0, 32'h0, 1, 8'h03);
    step("t5_p2_rel",  0, 3'd0, 32'h0, 0, 8'h00);

    // DATA write during RUN stops the counter
    step("t5_len3",     1, ADDR_LEN,   32'd3,  0, 8'h00);
    step("t5_p_stop",   1, ADDR_PULSE, 32'h01, 1, 8'h01);
    step("t5_data_run", 1, ADDR_DATA,  32'h80, 0, 8'h80);
    step("t5_stopped",  0, 3'd0, 32'h0, 0, 8'h80);
    step("t5_stopped2", 0, 3'd0, 32'h0, 0, 8'h80);

    // Asynchronous reset mid-RUN
    step("t5_len8",    1, ADDR_LEN,   32'd8,  0, 8'h80);
    step("t5_p_rst",   1, ADDR_PULSE, 32'h10, 1, 8'h90);
    step("t5_p_rst_r", 0, 3'd0, 32'h0, 1, 8'h90);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = ADDR_STATUS;
    #2;
    reset_n = 1'b0;
    #1;
    sb_push("t5_async_rst", 32'h0);
    sb_check({23'b0, bus_if.readdata[0], out_port});
    @(negedge clk);
    reset_n = 1'b1;
    rd("t5_rst_len", ADDR_LEN, 32'd16);
    step("t5_rst_idle", 0, 3'd0, 32'h0, 0, 8'h00);

`ifdef SPW_PIO_EDGE_IRQ_EN
    begin
      int n;
      step("t6_mask", 1, ADDR_IRQMASK, 32'h01, 0, 8'h00);
      rd("t6_mask_rd", ADDR_IRQMASK, 32'h01);
      in_port[0] = 1'b1;
      n = 0;
      while (irq !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      sb_push("t6_irq_set", 32'h1);
      sb_check({31'b0, irq});
      check_val("t6_irq_latency_le4", 32'(n <= 4), 32'd1);
      rd("t6_edge0", ADDR_EDGE, 32'h01);
      step("t6_edge_w1c", 1, ADDR_EDGE, 32'h01, 0, 8'h00);
      n = 0;
      while (irq !== 1'b0 && n < 4) begin
        @(negedge clk);
        n++;
      end
      sb_push("t6_irq_clr", 32'h0);
      sb_check({31'b0, irq});
      rd("t6_edge_clr", ADDR_EDGE, 32'h00);
      in_port[1] = 1'b1;
      repeat (6) @(negedge clk);
      rd("t6_edge1", ADDR_EDGE, 32'h02);
      sb_push("t6_irq_masked", 32'h0);
      sb_check({31'b0, irq});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
